// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store sequencer between execute stage and word-organised data memory
module load_store_unit #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [5:0]            req_opcode,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_WRITE,
    S_RESP
  } state_t;

  state_t state, state_next;

  logic [5:0]            op_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [1:0]            off_q;
  logic [31:0]           word_q;
  logic [31:0]           rdata_q;
  logic                  err_q;

  logic        req_err;
  logic [31:0] load_val;
  logic [31:0] merged;
  logic        sub_store_q;

  always_comb begin
    req_err = 1'b0;
    case (req_opcode)
      OP_LB, OP_LBU, OP_SB: req_err = 1'b0;
      OP_LH, OP_LHU, OP_SH: req_err = req_addr[0];
      OP_LW, OP_SW:         req_err = (req_addr[1:0] != 2'b00);
      default:              req_err = 1'b1;
    endcase
    if ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0) begin
      req_err = 1'b1;
    end
  end

  assign sub_store_q = (op_q == OP_SB) || (op_q == OP_SH);

  // Lane selection is little-endian: byte k lives in bits [8k+7:8k].
  always_comb begin
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    byte_sel = mem_rdata[{off_q, 3'b000} +: 8];
    half_sel = mem_rdata[{off_q[1], 4'b0000} +: 16];
    load_val = mem_rdata;
    case (op_q)
      OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_val = {24'd0, byte_sel};
      OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_val = {16'd0, half_sel};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    if (op_q == OP_SB) begin
      merged[{off_q, 3'b000} +: 8] = word_q[7:0];
    end else begin
      merged[{off_q[1], 4'b0000} +: 16] = word_q[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // word_q holds the store data from accept, then the merged word after CAPTURE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q    <= 6'd0;
      idx_q   <= '0;
      off_q   <= 2'd0;
      word_q  <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q    <= req_opcode;
            idx_q   <= req_addr[ADDR_WIDTH+1:2];
            off_q   <= req_addr[1:0];
            word_q  <= req_wdata;
            rdata_q <= 32'd0;
            err_q   <= req_err;
          end
        end
        S_CAPTURE: begin
          if (sub_store_q) begin
            word_q <= merged;
          end else begin
            rdata_q <= load_val;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    resp_err   = 1'b0;
    busy       = (state != S_IDLE);
    mem_addr   = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_wdata  = 32'd0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err) begin
            state_next = S_RESP;
          end else if (req_opcode == OP_SW) begin
            state_next = S_WRITE;
          end else begin
            state_next = S_READ;
          end
        end
      end
      S_READ: begin
        mem_read   = rst_n;
        mem_addr   = idx_q;
        state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        mem_addr   = idx_q;
        state_next = sub_store_q ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        // Gated by rst_n so a reset landing in WRITE drops the store.
        mem_write  = rst_n;
        mem_addr   = idx_q;
        mem_wdata  = word_q;
        state_next = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        if (resp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed table, corner sequences and random model checks for load_store_unit
module tb_load_store_unit;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [5:0]    req_opcode;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic          mem_read;
  logic          mem_write;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0]   mem [256];
  logic [31:0]   ref_mem [256];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_idx = '0;
  logic [31:0]   pl_val = 32'd0;

  always @(posedge clk) begin
    if (mem_read) mem_rdata <= mem[mem_addr];
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (mem_write) mem[mem_addr] <= mem_wdata;
  end

  int rd_total = 0;
  int wr_total = 0;
  int both_cnt = 0;
  logic [AW-1:0] strobe_addr = '0;

  always @(negedge clk) begin
    if (mem_read) begin rd_total++; strobe_addr = mem_addr; end
    if (mem_write) begin wr_total++; strobe_addr = mem_addr; end
    if (mem_read && mem_write) both_cnt++;
  end

  int passed = 0;
  int total = 0;
  int rd0, wr0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    pl_en = 1'b1; pl_idx = idx[AW-1:0]; pl_val = val;
    ref_mem[idx] = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge where resp_valid is first seen.
  task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat);
    int n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check("req_ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_opcode = op; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    rd0 = rd_total; wr0 = wr_total;
    @(negedge clk);
    // Junk on the request inputs while busy must be ignored.
    req_valid = 1'($urandom); req_opcode = 6'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
  endtask

  task automatic finish_resp();
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    check("ready_after_resp", {30'd0, req_ready, resp_valid}, 32'd2);
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic [31:0] word5;
    int          reads;
    int          writes;
  } vec_t;

  vec_t vecs[13];

  task automatic ref_exec(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int reads, output int writes);
    int size;
    int w;
    int sh;
    logic [31:0] v;
    logic [31:0] mask;
    case (op)
      6'h20, 6'h24, 6'h28: size = 1;
      6'h21, 6'h25, 6'h29: size = 2;
      6'h23, 6'h2B:        size = 4;
      default:             size = 0;
    endcase
    err = (size == 0) || (addr >= 32'd1024) || ((addr % size) != 0);
    rdata = 32'd0; lat = 1; reads = 0; writes = 0;
    if (!err) begin
      w  = int'(addr / 4);
      sh = 8 * int'(addr % 4);
      if (op < 6'h28) begin
        v = ref_mem[w] >> sh;
        if (size == 1) begin
          v = v & 32'hFF;
          if (op == 6'h20 && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (size == 2) begin
          v = v & 32'hFFFF;
          if (op == 6'h21 && v >= 32'h8000) v = v | 32'hFFFF0000;
        end
        rdata = v; lat = 3; reads = 1;
      end else if (size == 4) begin
        ref_mem[w] = wdata; lat = 2; writes = 1;
      end else begin
        mask = ((size == 1) ? 32'hFF : 32'hFFFF) << sh;
        ref_mem[w] = (ref_mem[w] & ~mask) | ((wdata << sh) & mask);
        lat = 4; reads = 1; writes = 1;
      end
    end
  endtask

  logic [5:0] op_pool [9] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h22};

  initial begin
    int lat;
    int mism;
    logic [31:0] held;
    logic [31:0] e_rdata;
    logic        e_err;
    int          e_lat, e_rd, e_wr;
    logic [5:0]  op;
    logic [31:0] addr, wdata;

    vecs[0]  = '{6'h23, 32'h14,  32'h0,        32'h8899AABB, 1'b0, 3, 32'h8899AABB, 1, 0};
    vecs[1]  = '{6'h20, 32'h17,  32'h0,        32'hFFFFFF88, 1'b0, 3, 32'h8899AABB, 1, 0};
    vecs[2]  = '{6'h24, 32'h17,  32'h0,        32'h00000088, 1'b0, 3, 32'h8899AABB, 1, 0};
    vecs[3]  = '{6'h21, 32'h14,  32'h0,        32'hFFFFAABB, 1'b0, 3, 32'h8899AABB, 1, 0};
    vecs[4]  = '{6'h25, 32'h16,  32'h0,        32'h00008899, 1'b0, 3, 32'h8899AABB, 1, 0};
    vecs[5]  = '{6'h28, 32'h15,  32'h123456CC, 32'h0,        1'b0, 4, 32'h8899CCBB, 1, 1};
    vecs[6]  = '{6'h29, 32'h16,  32'h0000ABCD, 32'h0,        1'b0, 4, 32'hABCDAABB, 1, 1};
    vecs[7]  = '{6'h2B, 32'h14,  32'hDEADBEEF, 32'h0,        1'b0, 2, 32'hDEADBEEF, 0, 1};
    vecs[8]  = '{6'h23, 32'h16,  32'h0,        32'h0,        1'b1, 1, 32'h8899AABB, 0, 0};
    vecs[9]  = '{6'h29, 32'h11,  32'hFFFF,     32'h0,        1'b1, 1, 32'h8899AABB, 0, 0};
    vecs[10] = '{6'h22, 32'h14,  32'h0,        32'h0,        1'b1, 1, 32'h8899AABB, 0, 0};
    vecs[11] = '{6'h23, 32'h400, 32'h0,        32'h0,        1'b1, 1, 32'h8899AABB, 0, 0};
    vecs[12] = '{6'h28, 32'h14,  32'hFFFFFF77, 32'h0,        1'b0, 4, 32'h8899AA77, 1, 1};

    rst_n = 1'b0; req_valid = 1'b0; req_opcode = 6'd0; req_addr = 32'd0; req_wdata = 32'd0;
    resp_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) poke(i, $urandom);
    poke(5, 32'h8899AABB);
    check("reset_ctrl", {26'd0, req_ready, resp_valid, resp_err, busy, mem_read, mem_write}, 32'h20);
    check("reset_mem_addr", {24'd0, mem_addr}, 32'd0);
    check("reset_mem_wdata", mem_wdata, 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      poke(5, 32'h8899AABB);
      issue(vecs[i].op, vecs[i].addr, vecs[i].wdata, lat);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_rdata", i), resp_rdata, vecs[i].rdata);
      check($sformatf("v%0d_err", i), {31'd0, resp_err}, {31'd0, vecs[i].err});
      finish_resp();
      check($sformatf("v%0d_reads", i), rd_total - rd0, vecs[i].reads);
      check($sformatf("v%0d_writes", i), wr_total - wr0, vecs[i].writes);
      check($sformatf("v%0d_word5", i), mem[5], vecs[i].word5);
      if (vecs[i].reads + vecs[i].writes > 0)
        check($sformatf("v%0d_strobe_addr", i), {24'd0, strobe_addr}, vecs[i].addr >> 2);
    end

    poke(5, 32'h8899AABB);
    resp_ready = 1'b0;
    issue(6'h23, 32'h14, 32'h0, lat);
    check("hold_lat", lat, 3);
    held = resp_rdata;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d", k), {29'd0, resp_valid, req_ready, resp_err}, 32'h4);
      check($sformatf("hold%0d_rdata", k), resp_rdata, 32'h8899AABB);
    end
    check("hold_first_rdata", held, 32'h8899AABB);
    finish_resp();

    poke(5, 32'h8899AABB);
    req_valid = 1'b1; req_opcode = 6'h28; req_addr = 32'h15; req_wdata = 32'h123456CC;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_seq_read", {31'd0, mem_read}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("rst_seq_write", {31'd0, mem_write}, 32'd1);
    check("rst_seq_wdata", mem_wdata, 32'h8899CCBB);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_ctrl", {26'd0, req_ready, resp_valid, resp_err, busy, mem_read, mem_write}, 32'h20);
    check("rst_mid_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_mid_wdata", mem_wdata, 32'd0);
    check("rst_mid_word5", mem[5], 32'h8899AABB);
    rst_n = 1'b1;
    @(negedge clk);
    issue(6'h23, 32'h14, 32'h0, lat);
    check("after_rst_lw", resp_rdata, 32'h8899AABB);
    finish_resp();

    for (int i = 0; i < 200; i++) begin
      op = op_pool[$urandom_range(0, 8)];
      if ($urandom_range(0, 15) == 0) addr = $urandom;
      else addr = $urandom_range(0, 1023);
      wdata = $urandom;
      ref_exec(op, addr, wdata, e_rdata, e_err, e_lat, e_rd, e_wr);
      issue(op, addr, wdata, lat);
      check($sformatf("r%0d_lat op%h a%h", i, op, addr), lat, e_lat);
      check($sformatf("r%0d_rdata op%h a%h", i, op, addr), resp_rdata, e_rdata);
      check($sformatf("r%0d_err op%h a%h", i, op, addr), {31'd0, resp_err}, {31'd0, e_err});
      finish_resp();
      check($sformatf("r%0d_strobes", i), {rd_total - rd0, wr_total - wr0}, {e_rd, e_wr});
    end

    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
    check("final_mem_mismatches", mism, 0);
    check("read_write_overlap", both_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sequences every load and store between the execute stage and the word-organised data memory (256 x 32 by default).
- Converts byte addresses to word indices and performs sub-word stores (sb/sh) as read-modify-write.
- Sign- or zero-extends sub-word loads and flags misaligned, out-of-range or illegal accesses.
- Upstream: valid/ready request handshake. Downstream: single-cycle mem_read/mem_write strobes to data memory.

Parameters:
- ADDR_WIDTH, 8, word-index width; memory depth = 2^ADDR_WIDTH words.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_opcode  input  6  0x20 lb, 0x21 lh, 0x23 lw, 0x24 lbu, 0x25 lhu, 0x28 sb, 0x29 sh, 0x2B sw.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer accepts response.
- resp_rdata  output  32  extended load result; 0 for stores and errors.
- resp_err  output  1  access rejected.
- busy  output  1  state != IDLE.
- mem_addr  output  ADDR_WIDTH  word index = req_addr[ADDR_WIDTH+1:2].
- mem_read  output  1  read strobe.
- mem_write  output  1  write strobe.
- mem_wdata  output  32  word to write.
- mem_rdata  input  32  memory word, valid the cycle after mem_read.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-low on rst_n.
- Reset values: state=IDLE; req_ready=1; all other outputs 0.
- Reset mid-operation returns the unit to IDLE on that edge. Any pending write is dropped; mem_write must not assert afterwards.
- Requests are latched (opcode, addr, wdata) in IDLE when req_valid=1. req_ready=1 only in IDLE.
- Error check at accept:
  - Unknown opcode.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - addr[31:ADDR_WIDTH+2] != 0.
  - On error: go to RESP with resp_err=1 and resp_rdata=0; no memory strobe ever asserts.
- FSM states: IDLE, READ, CAPTURE, WRITE, RESP.
  - IDLE -> READ for loads, sb and sh.
  - IDLE -> WRITE for sw.
  - IDLE -> RESP on error.
  - READ: mem_read=1 for exactly one cycle. -> CAPTURE.
  - CAPTURE: register mem_rdata. Loads -> RESP; sb/sh merge -> WRITE.
  - WRITE: mem_write=1 for exactly one cycle, mem_wdata=merged or sw word. -> RESP.
  - RESP: resp_valid=1. Hold resp_valid, resp_rdata and resp_err stable until resp_ready=1, then -> IDLE.
- mem_addr is held at the latched word index throughout READ/CAPTURE/WRITE, and is 0 in IDLE.
- Byte lanes are little-endian: offset k selects bits [8k+7:8k]; halfword offset 2 selects [31:16].
- Loads: lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word unchanged.
- Stores: sb replaces only the addressed byte with wdata[7:0]; sh replaces only the addressed halfword with wdata[15:0]. Other bytes retain the value read in CAPTURE.
- Latency from accept edge to resp_valid:
  - lw/lb/lh/lbu/lhu: 3 cycles.
  - sw: 2 cycles.
  - sb/sh: 4 cycles.
  - error: 1 cycle.
- No new request is accepted in the cycle resp_ready is taken; IDLE is re-entered first. Back-to-back throughput is therefore one request per latency+1 cycles.
- Request inputs are ignored when not in IDLE.
- mem_read and mem_write are never asserted together.

Test Plan:
- Reset with mem word 5 = 0x8899AABB; lw addr 0x14 -> mem_read high one cycle at word 5; resp_rdata=0x8899AABB, resp_err=0, resp_valid 3 cycles after accept.
- Same word; lb addr 0x17 -> 0xFFFFFF88. lbu addr 0x17 -> 0x00000088. lh addr 0x14 -> 0xFFFFAABB. lhu addr 0x16 -> 0x00008899.
- sb addr 0x15 with wdata 0x123456CC onto 0x8899AABB -> one mem_write with mem_wdata=0x8899CCBB. sh addr 0x16 with wdata 0x0000ABCD -> 0xABCDAABB.
- Errors: lw addr 0x16, sh addr 0x11, opcode 0x22, and lw addr 0x400 (ADDR_WIDTH=8) -> each gives resp_err=1, resp_rdata=0, resp_valid 1 cycle after accept, no strobes.
- Hold resp_ready=0 for 5 cycles -> resp_valid and data stay stable, req_ready=0. After the resp_ready pulse, req_ready=1 the next cycle.
- Drive rst_n=0 during WRITE of an sb -> all outputs 0 on the next edge; memory word unchanged; next lw returns the original value.
